// File: rtl/mux_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin mux-select arbiter.
package mux_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int N_DEF        = 4;
   localparam int SEL_W_DEF    = 2;
   localparam int MAX_HOLD_DEF = 16;
   localparam int HOLD_W_DEF   = 5;

   // Index of the set bit in a one-hot vector; OR-reduction keeps it a flat gate tree.
   function automatic int onehot_to_idx(input logic [31:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) r = r | i;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [2*N-1:0] req2;
   logic [2*N-1:0] keep_mask;
   logic [2*N-1:0] masked;
   logic [2*N-1:0] lowest;
   int             pos;

   // Lower copy keeps only indices >= ptr; the upper copy supplies the wrapped-around ones.
   for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign keep_mask[gi] = (SEL_W'(gi) >= ptr);
   end
   assign keep_mask[2*N-1:N] = '1;

   assign req2   = {req, req};
   assign masked = req2 & keep_mask;
   assign lowest = masked & (~masked + {{(2*N-1){1'b0}}, 1'b1});
   assign any    = |req;

   always_comb begin
      pos = onehot_to_idx(32'(lowest));
      idx = (pos >= N) ? SEL_W'(pos - N) : SEL_W'(pos);
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared N:1 mux select; grants are held until release or hold timeout.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int SEL_W    = SEL_W_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int HOLD_W   = HOLD_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] sel,
   output logic             valid,
   output logic             expired
);

   if (N < 2 || N > 16 || SEL_W != $clog2(N)) begin : g_bad_sel
      $error("mux_rr_arbiter: N must be 2..16 and SEL_W must equal clog2(N)");
   end
   if ((2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_hold
      $error("mux_rr_arbiter: HOLD_W too narrow for MAX_HOLD");
   end

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N - 1);

   arb_state_t        state_q, state_d;
   logic [N-1:0]      grant_q, grant_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              valid_q, valid_d;
   logic              expired_q, expired_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;
   logic             owner_req;
   logic             timeout;
   logic             release_now;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // In GRANT, sel_q is the owner index.
   assign owner_req   = req[sel_q];
   assign timeout     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
   assign release_now = !owner_req || done || timeout;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      valid_d    = valid_q;
      expired_d  = 1'b0;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            valid_d = 1'b0;
            if (pick_any) begin
               grant_d[pick_idx] = 1'b1;
               sel_d             = pick_idx;
               valid_d           = 1'b1;
               hold_cnt_d        = '0;
               state_d           = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               grant_d   = '0;
               valid_d   = 1'b0;
               ptr_d     = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
               expired_d = timeout && owner_req && !done;
               state_d   = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         sel_q      <= '0;
         valid_q    <= 1'b0;
         expired_q  <= 1'b0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         valid_q    <= valid_d;
         expired_q  <= expired_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign grant   = grant_q;
   assign sel     = sel_q;
   assign valid   = valid_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and random checks of mux_rr_arbiter against a cycle-level behavioural model.
module tb_mux_rr_arbiter;

   localparam int N        = 4;
   localparam int SEL_W    = 2;
   localparam int MAX_HOLD = 16;
   localparam int HOLD_W   = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req = '0;
   logic             done = 1'b0;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] sel;
   logic             valid;
   logic             expired;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: owner (-1 = none), cycles the owner has been shown, search pointer, last select.
   int m_owner   = -1;
   int m_held    = 0;
   int m_ptr     = 0;
   int m_sel     = 0;
   bit m_expired = 1'b0;

   mux_rr_arbiter #(
      .N        (N),
      .SEL_W    (SEL_W),
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .sel     (sel),
      .valid   (valid),
      .expired (expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step();
      bit timed;
      bit rel;
      if (rst) begin
         m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_expired = 1'b0;
      end else if (m_owner < 0) begin
         m_expired = 1'b0;
         for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (req[k]) begin
               m_owner = k; m_sel = k; m_held = 1;
               break;
            end
         end
      end else begin
         timed = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
         rel   = !req[m_owner] || done || timed;
         if (rel) begin
            m_expired = timed && req[m_owner] && !done;
            m_ptr     = (m_owner + 1) % N;
            m_owner   = -1;
         end else begin
            m_held++;
            m_expired = 1'b0;
         end
      end
   endtask

   task automatic tick();
      logic [N-1:0] eg;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      $display("cyc %0d rst=%b req=%b done=%b grant=%b sel=%0d valid=%b expired=%b",
               cyc, rst, req, done, grant, sel, valid, expired);
      chk("model_grant", 32'(grant), 32'(eg));
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_valid", 32'(valid), 32'(m_owner >= 0));
      chk("model_expired", 32'(expired), 32'(m_expired));
   endtask

   initial begin
      logic [N-1:0] seen[$];
      logic         prev_valid;
      int           n;

      // Reset
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_sel", 32'(sel), 32'h0);
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_expired", 32'(expired), 32'h0);

      // 1: single requester, release by dropping req; ptr then points at 3
      req = 4'b0100;
      tick();
      chk("t1_grant", 32'(grant), 32'h4);
      chk("t1_sel", 32'(sel), 32'd2);
      chk("t1_valid", 32'(valid), 32'h1);
      tick(); tick(); tick();
      req = 4'b0000;
      tick();
      chk("t1_release", 32'(grant), 32'h0);
      req = 4'b1001;
      tick();
      chk("t1_ptr3", 32'(grant), 32'h8);
      req = 4'b0000;
      tick();

      // 2: all requesting, done on each third grant cycle
      req = 4'b1111;
      prev_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         done = (m_owner >= 0) && (m_held == 3);
         tick();
         if (valid && !prev_valid) seen.push_back(grant);
         prev_valid = valid;
      end
      done = 1'b0;
      chk("t2_count", 32'(seen.size()), 32'd5);
      if (seen.size() >= 5) begin
         chk("t2_g0", 32'(seen[0]), 32'h1);
         chk("t2_g1", 32'(seen[1]), 32'h2);
         chk("t2_g2", 32'(seen[2]), 32'h4);
         chk("t2_g3", 32'(seen[3]), 32'h8);
         chk("t2_g4", 32'(seen[4]), 32'h1);
      end
      req = 4'b0000;
      tick(); tick();

      // 3: hold limit on a lone requester
      req = 4'b0001;
      tick();
      n = 0;
      for (int i = 0; i < 40 && grant == 4'b0001; i++) begin
         n++;
         tick();
      end
      chk("t3_hold_len", 32'(n), 32'd16);
      chk("t3_expired", 32'(expired), 32'h1);
      chk("t3_gap_grant", 32'(grant), 32'h0);
      tick();
      chk("t3_regrant", 32'(grant), 32'h1);
      chk("t3_expired_pulse", 32'(expired), 32'h0);
      req = 4'b0000;
      tick(); tick();

      // 4: owner keeps grant despite a lower-index request
      req = 4'b0010;
      tick();
      chk("t4_own1", 32'(grant), 32'h2);
      req = 4'b0011;
      tick(); tick(); tick();
      chk("t4_keep", 32'(grant), 32'h2);
      req = 4'b0101;
      tick();
      chk("t4_release", 32'(grant), 32'h0);
      tick();
      chk("t4_next2", 32'(grant), 32'h4);
      req = 4'b0000;
      tick(); tick();
      req = 4'b0010;
      tick();
      chk("t4b_own1", 32'(grant), 32'h2);
      req = 4'b0011;
      tick();
      req = 4'b0001;
      tick();
      tick();
      chk("t4b_wrap0", 32'(grant), 32'h1);
      req = 4'b0000;
      tick(); tick();

      // 5: done coinciding with timeout, then reset mid-grant
      req = 4'b0001;
      tick();
      for (int i = 0; i < 40 && m_held < MAX_HOLD; i++) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t5_done_wins", 32'(expired), 32'h0);
      chk("t5_released", 32'(grant), 32'h0);
      req = 4'b1000;
      tick();
      chk("t5_own3", 32'(grant), 32'h8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_grant", 32'(grant), 32'h0);
      chk("t5_rst_sel", 32'(sel), 32'h0);
      req = 4'b1010;
      tick();
      chk("t5_after_rst", 32'(grant), 32'h2);

      // 6: idle with done pulses; sel must hold
      req = 4'b0000;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t6_sel_hold", 32'(sel), 32'd1);
         chk("t6_idle", 32'(valid), 32'h0);
      end

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         req  = N'($urandom);
         done = ($urandom_range(7) == 0);
         rst  = ($urandom_range(63) == 0);
         tick();
      end
      rst = 1'b0; req = '0; done = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
